pwm_fade_ctrl: RTL and testbench
================================

Name: pwm_fade_ctrl

Overview:
- Controller for a bank of NUM_CH PWM units. Holds per-channel duty state and ramps each channel's duty value toward a programmed target in fixed steps, paced by the PWM units' period pulses.
- A single round-robin update engine is shared across all channels and serves one channel per clock.
- Software and bus-side logic configure channels through a valid/ready write port. The block drives the pwm_value inputs of the PWM units.

Parameters:
- NUM_CH, 4, number of PWM channels controlled (2..16).
- CH_W, 2, width of the channel index (clog2(NUM_CH)).

Ports:
- pwm_clk  in  1  single clock for all logic.
- pwm_reset  in  1  synchronous, active-high reset.
- cfg_valid  in  1  configuration write request.
- cfg_ready  out  1  configuration write accepted when high together with cfg_valid.
- cfg_ch  in  CH_W  target channel of the write.
- cfg_target  in  8  final duty value.
- cfg_step  in  8  duty increment per step; 0 means jump directly to target.
- cfg_interval  in  8  PWM periods per step, minus 1.
- pwm_period_in  in  NUM_CH  period-boundary indication from each PWM unit.
- pwm_value_o  out  NUM_CH*8  current duty per channel; channel i occupies bits [8i+7:8i].
- ch_busy  out  NUM_CH  channel i current value is not equal to its target.
- ch_done  out  NUM_CH  one-cycle pulse when channel i reaches its target.
- tick_overrun  out  1  sticky flag: a tick arrived while that channel was already pending.

Behaviour:
- Reset (synchronous): when pwm_reset=1 at a clock edge, all of the following are cleared:
  - cur, tgt, step, interval and icnt all become 0.
  - pend becomes 0 and the round-robin pointer becomes 0.
  - cfg_ready=0, pwm_value_o=0, ch_busy=0, ch_done=0, tick_overrun=0.
  - This applies mid-ramp as well; the ramp is abandoned.
- cfg_ready=1 on every cycle that is not in reset.
- Config write (cfg_valid&cfg_ready at edge t), at edge t the channel takes:
  - tgt=cfg_target, step=cfg_step, interval=cfg_interval, icnt=0.
  - cur is not changed; the ramp continues from the present value.
  - A write with cfg_ch >= NUM_CH is accepted and ignored.
- Tick capture:
  - Every cycle with pwm_period_in[i]=1 sets pend[i] at the next edge, so a level held high ticks every cycle.
  - If pend[i] is already set and not cleared by service in the same cycle, tick_overrun is set. The tick is merged, not queued.
- Arbiter:
  - Each cycle it grants the first set pend bit at or after the pointer, searching with wrap-around.
  - At the edge the granted pend bit clears and the pointer moves to grant+1 (mod NUM_CH). With no grant, the pointer holds.
  - A tick and a grant on the same channel in the same cycle leave pend set, with no overrun.
  - Worst-case wait from pend set to service is NUM_CH cycles.
- Service of channel i (registered at the grant edge):
  - If cur==tgt: no change.
  - Else if icnt<interval: icnt+1.
  - Else:
    - icnt=0.
    - cur moves toward tgt by step, clamped to tgt with no overshoot. Compute in 9 bits: up = min(cur+step, tgt); down = max(cur-step, tgt).
    - step=0 sets cur=tgt.
    - If the new cur==tgt, ch_done[i] pulses for the following cycle.
- Write/service collision: a config write to the channel being serviced in the same cycle wins. The service result is discarded, and the pend bit is still consumed.
- Latency:
  - Tick at cycle t, pend at t+1, earliest grant at t+1, pwm_value_o updated at t+2.
  - A config write never changes pwm_value_o directly.
- Outputs are registered from the cur registers. ch_busy = (cur!=tgt), registered.

Test Plan:
- Reset: drive pwm_reset=1 for 2 cycles while a ramp is active -> all outputs 0, pend cleared, cfg_ready=0 during reset; normal operation resumes 1 cycle after deassert.
- Up ramp: ch0 target=10, step=3, interval=0, one-cycle tick every 8 cycles -> values 3,6,9,10; ch_done[0] pulses once after 10; ch_busy[0] falls with it.
- Down ramp with interval: ch1 at 200, write target=100, step=50, interval=2 -> values 150 after 3 ticks and 100 after 6 ticks; no undershoot.
- Arbitration: all 4 channels ticked in the same cycle with pointer=2 -> service order 2,3,0,1 on consecutive cycles, one value change per cycle.
- Overrun and collision:
  - pwm_period_in[3] held high while channels 0-2 also pend -> tick_overrun=1 and sticky until reset.
  - A write to a channel in its grant cycle -> the new cfg applies, with no step taken that cycle.
- step=0 and invalid channel:
  - Write step=0, target=77 -> cur=77 on the first serviced tick, with ch_done.
  - A write with cfg_ch=4 when NUM_CH=4 -> no state change.

Source files
------------

// File: rtl/pwm_fade_ctrl_if.sv
// Configuration write port of the PWM fade controller: valid/ready handshake
// carrying one channel's ramp target, step size and step interval.
interface pwm_fade_ctrl_if #(
    parameter int unsigned CH_W = 2
);
    logic            cfg_valid;
    logic            cfg_ready;
    logic [CH_W-1:0] cfg_ch;
    logic [7:0]      cfg_target;
    logic [7:0]      cfg_step;
    logic [7:0]      cfg_interval;

    modport master (
        output cfg_valid,
        output cfg_ch,
        output cfg_target,
        output cfg_step,
        output cfg_interval,
        input  cfg_ready
    );

    modport slave (
        input  cfg_valid,
        input  cfg_ch,
        input  cfg_target,
        input  cfg_step,
        input  cfg_interval,
        output cfg_ready
    );
endinterface

// File: rtl/pwm_fade_ctrl.sv
// Shared round-robin fade engine: ramps each PWM channel's duty toward its target,
// one channel serviced per clock, paced by the PWM units' period ticks.
module pwm_fade_ctrl #(
    parameter int unsigned NUM_CH = 4,
    parameter int unsigned CH_W   = 2
) (
    input  logic                pwm_clk,
    input  logic                pwm_reset,
    pwm_fade_ctrl_if.slave      cfg,
    input  logic [NUM_CH-1:0]   pwm_period_in,
    output logic [NUM_CH*8-1:0] pwm_value_o,
    output logic [NUM_CH-1:0]   ch_busy,
    output logic [NUM_CH-1:0]   ch_done,
    output logic                tick_overrun
);

    logic [7:0] cur_q  [NUM_CH];
    logic [7:0] cur_d  [NUM_CH];
    logic [7:0] tgt_q  [NUM_CH];
    logic [7:0] tgt_d  [NUM_CH];
    logic [7:0] step_q [NUM_CH];
    logic [7:0] step_d [NUM_CH];
    logic [7:0] ival_q [NUM_CH];
    logic [7:0] ival_d [NUM_CH];
    logic [7:0] icnt_q [NUM_CH];
    logic [7:0] icnt_d [NUM_CH];

    logic [NUM_CH-1:0] pend_q, pend_d;
    logic [NUM_CH-1:0] busy_q, busy_d;
    logic [NUM_CH-1:0] done_q, done_d;
    logic              ovr_q, ovr_d;
    logic              rdy_q;
    logic [CH_W-1:0]   ptr_q, ptr_d;

    logic [2*NUM_CH-1:0] pend_dbl;
    logic [NUM_CH-1:0]   pend_rot;
    logic [NUM_CH-1:0]   gnt_oh;
    logic                gnt_vld;
    int unsigned         gnt_idx;
    logic                cfg_fire;

    logic [8:0] sum9    [NUM_CH];
    logic [8:0] dif9    [NUM_CH];
    logic [7:0] stepped [NUM_CH];

    assign cfg_fire = cfg.cfg_valid & rdy_q;

    // Rotate pend so bit 0 is the pointer position; the lowest set bit is the grant.
    always_comb begin
        pend_dbl = {pend_q, pend_q} >> ptr_q;
        pend_rot = pend_dbl[NUM_CH-1:0];
        gnt_vld  = 1'b0;
        gnt_idx  = 0;
        for (int k = 0; k < NUM_CH; k++) begin
            if (!gnt_vld && pend_rot[k]) begin
                gnt_vld = 1'b1;
                gnt_idx = (32'(ptr_q) + 32'(k)) % NUM_CH;
            end
        end
        gnt_oh = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            gnt_oh[i] = gnt_vld && (gnt_idx == i);
        end
        ptr_d = gnt_vld ? CH_W'((gnt_idx + 1) % NUM_CH) : ptr_q;
    end

    // Candidate next duty per channel, clamped to the target in 9-bit arithmetic.
    always_comb begin
        for (int i = 0; i < NUM_CH; i++) begin
            sum9[i] = {1'b0, cur_q[i]} + {1'b0, step_q[i]};
            dif9[i] = {1'b0, cur_q[i]} - {1'b0, step_q[i]};
            if (step_q[i] == 8'd0) begin
                stepped[i] = tgt_q[i];
            end else if (cur_q[i] < tgt_q[i]) begin
                stepped[i] = (sum9[i] > {1'b0, tgt_q[i]}) ? tgt_q[i] : sum9[i][7:0];
            end else begin
                stepped[i] = (dif9[i][8] || (dif9[i] < {1'b0, tgt_q[i]})) ?
                             tgt_q[i] : dif9[i][7:0];
            end
        end
    end

    always_comb begin
        pend_d = (pend_q & ~gnt_oh) | pwm_period_in;
        ovr_d  = ovr_q | (|(pend_q & ~gnt_oh & pwm_period_in));
        done_d = '0;
        busy_d = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            cur_d[i]  = cur_q[i];
            tgt_d[i]  = tgt_q[i];
            step_d[i] = step_q[i];
            ival_d[i] = ival_q[i];
            icnt_d[i] = icnt_q[i];
            if (gnt_oh[i] && (cur_q[i] != tgt_q[i])) begin
                if (icnt_q[i] < ival_q[i]) begin
                    icnt_d[i] = icnt_q[i] + 8'd1;
                end else begin
                    icnt_d[i] = 8'd0;
                    cur_d[i]  = stepped[i];
                    done_d[i] = (stepped[i] == tgt_q[i]);
                end
            end
            // A write landing on the serviced channel overrides that service entirely.
            if (cfg_fire && (32'(cfg.cfg_ch) == i)) begin
                cur_d[i]  = cur_q[i];
                tgt_d[i]  = cfg.cfg_target;
                step_d[i] = cfg.cfg_step;
                ival_d[i] = cfg.cfg_interval;
                icnt_d[i] = 8'd0;
                done_d[i] = 1'b0;
            end
            busy_d[i] = (cur_d[i] != tgt_d[i]);
        end
    end

    always_ff @(posedge pwm_clk) begin
        if (pwm_reset) begin
            for (int i = 0; i < NUM_CH; i++) begin
                cur_q[i]  <= '0;
                tgt_q[i]  <= '0;
                step_q[i] <= '0;
                ival_q[i] <= '0;
                icnt_q[i] <= '0;
            end
            pend_q <= '0;
            busy_q <= '0;
            done_q <= '0;
            ovr_q  <= 1'b0;
            rdy_q  <= 1'b0;
            ptr_q  <= '0;
        end else begin
            cur_q  <= cur_d;
            tgt_q  <= tgt_d;
            step_q <= step_d;
            ival_q <= ival_d;
            icnt_q <= icnt_d;
            pend_q <= pend_d;
            busy_q <= busy_d;
            done_q <= done_d;
            ovr_q  <= ovr_d;
            rdy_q  <= 1'b1;
            ptr_q  <= ptr_d;
        end
    end

    always_comb begin
        pwm_value_o = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            pwm_value_o[8*i +: 8] = cur_q[i];
        end
    end

    assign cfg.cfg_ready = rdy_q;
    assign ch_busy       = busy_q;
    assign ch_done       = done_q;
    assign tick_overrun  = ovr_q;

endmodule

// File: tb/tb_pwm_fade_ctrl.sv
// Bench for pwm_fade_ctrl: table of ramp programs plus hand sequences, with a
// reference model feeding a scoreboard of expected duty changes.
module tb_pwm_fade_ctrl;
    localparam int NUM_CH = 4;
    localparam int CH_W   = 3;  // wide enough to address a non-existent channel

    logic                pwm_clk;
    logic                pwm_reset;
    logic [NUM_CH-1:0]   pwm_period_in;
    logic [NUM_CH*8-1:0] pwm_value_o;
    logic [NUM_CH-1:0]   ch_busy;
    logic [NUM_CH-1:0]   ch_done;
    logic                tick_overrun;

    pwm_fade_ctrl_if #(.CH_W(CH_W)) cfg ();

    pwm_fade_ctrl #(.NUM_CH(NUM_CH), .CH_W(CH_W)) dut (
        .pwm_clk       (pwm_clk),
        .pwm_reset     (pwm_reset),
        .cfg           (cfg),
        .pwm_period_in (pwm_period_in),
        .pwm_value_o   (pwm_value_o),
        .ch_busy       (ch_busy),
        .ch_done       (ch_done),
        .tick_overrun  (tick_overrun)
    );

    initial begin
        pwm_clk = 1'b0;
        forever #5 pwm_clk = ~pwm_clk;
    end

    typedef struct {
        int ch;
        int val;
        bit done;
    } sb_t;

    typedef struct {
        bit wr;
        int ch;
        int tgt;
        int step;
        int ival;
        int nticks;
        int exp_val;
        bit exp_busy;
    } vec_t;

    sb_t  sb_q[$];
    vec_t vecs[10];
    int   n_chk  = 0;
    int   n_pass = 0;
    bit   mon_en = 1'b0;
    int   m_cur [NUM_CH];
    int   m_tgt [NUM_CH];
    int   m_step[NUM_CH];
    int   m_ival[NUM_CH];
    int   m_icnt[NUM_CH];

    task automatic chk(string name, int act, int exp);
        n_chk++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    function automatic int val(int ch);
        return int'(pwm_value_o[8*ch +: 8]);
    endfunction

    task automatic clk1();
        @(posedge pwm_clk);
        #1;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NUM_CH; i++) begin
            m_cur[i] = 0; m_tgt[i] = 0; m_step[i] = 0; m_ival[i] = 0; m_icnt[i] = 0;
        end
    endtask

    task automatic model_write(int ch, int t, int s, int iv);
        if (ch < NUM_CH) begin
            m_tgt[ch] = t; m_step[ch] = s; m_ival[ch] = iv; m_icnt[ch] = 0;
        end
    endtask

    task automatic model_service(int c);
        int nv;
        if (m_cur[c] != m_tgt[c]) begin
            if (m_icnt[c] < m_ival[c]) begin
                m_icnt[c]++;
            end else begin
                m_icnt[c] = 0;
                if (m_step[c] == 0) nv = m_tgt[c];
                else if (m_cur[c] < m_tgt[c])
                    nv = (m_cur[c] + m_step[c] > m_tgt[c]) ? m_tgt[c] : m_cur[c] + m_step[c];
                else
                    nv = (m_cur[c] - m_step[c] < m_tgt[c]) ? m_tgt[c] : m_cur[c] - m_step[c];
                m_cur[c] = nv;
                sb_q.push_back('{c, nv, nv == m_tgt[c]});
            end
        end
    endtask

    task automatic cfg_write(int ch, int t, int s, int iv);
        cfg.cfg_valid    = 1'b1;
        cfg.cfg_ch       = CH_W'(ch);
        cfg.cfg_target   = 8'(t);
        cfg.cfg_step     = 8'(s);
        cfg.cfg_interval = 8'(iv);
        clk1();
        cfg.cfg_valid = 1'b0;
        model_write(ch, t, s, iv);
    endtask

    task automatic tick(int ch);
        pwm_period_in     = '0;
        pwm_period_in[ch] = 1'b1;
        model_service(ch);
        clk1();
        pwm_period_in = '0;
        repeat (7) clk1();
    endtask

    // Scoreboard: every change of a channel's duty must match the next expected event.
    initial begin
        int  prev[NUM_CH];
        bit  any;
        sb_t e;
        for (int i = 0; i < NUM_CH; i++) prev[i] = 0;
        forever begin
            @(negedge pwm_clk);
            if (mon_en) begin
                any = 1'b0;
                for (int i = 0; i < NUM_CH; i++) begin
                    if (val(i) != prev[i]) begin
                        any = 1'b1;
                        if (sb_q.size() == 0) begin
                            n_chk++;
                            $display("FAIL sb_unexpected: ch%0d changed to %0d, expected no change",
                                     i, val(i));
                        end else begin
                            e = sb_q.pop_front();
                            chk("sb_ch", i, e.ch);
                            chk("sb_val", val(i), e.val);
                            chk("sb_done", int'(ch_done), e.done ? (1 << e.ch) : 0);
                        end
                    end
                end
                if (!any && ch_done != '0) begin
                    n_chk++;
                    $display("FAIL done_no_change: ch_done=%0h, expected 0", ch_done);
                end
            end
            for (int i = 0; i < NUM_CH; i++) prev[i] = val(i);
        end
    end

    initial begin
        vecs[0] = '{1, 0, 10,  3,   0, 4, 10,  1'b0};
        vecs[1] = '{1, 1, 200, 0,   0, 1, 200, 1'b0};
        vecs[2] = '{1, 1, 100, 50,  2, 3, 150, 1'b1};
        vecs[3] = '{0, 1, 0,   0,   0, 3, 100, 1'b0};
        vecs[4] = '{1, 2, 77,  0,   0, 1, 77,  1'b0};
        vecs[5] = '{1, 3, 255, 100, 0, 2, 200, 1'b1};
        vecs[6] = '{0, 3, 0,   0,   0, 1, 255, 1'b0};
        vecs[7] = '{1, 3, 0,   200, 0, 2, 0,   1'b0};
        vecs[8] = '{1, 0, 10,  5,   1, 3, 10,  1'b0};
        vecs[9] = '{1, 0, 250, 120, 0, 1, 130, 1'b1};

        model_reset();
        pwm_reset        = 1'b1;
        pwm_period_in    = '0;
        cfg.cfg_valid    = 1'b0;
        cfg.cfg_ch       = '0;
        cfg.cfg_target   = '0;
        cfg.cfg_step     = '0;
        cfg.cfg_interval = '0;
        repeat (3) clk1();
        chk("rst_ready", int'(cfg.cfg_ready), 0);
        chk("rst_value", int'(pwm_value_o == '0), 1);
        chk("rst_busy", int'(ch_busy), 0);
        chk("rst_done", int'(ch_done), 0);
        chk("rst_ovr", int'(tick_overrun), 0);
        pwm_reset = 1'b0;
        clk1();
        chk("ready_after_rst", int'(cfg.cfg_ready), 1);
        mon_en = 1'b1;

        for (int v = 0; v < 10; v++) begin
            if (vecs[v].wr) cfg_write(vecs[v].ch, vecs[v].tgt, vecs[v].step, vecs[v].ival);
            for (int n = 0; n < vecs[v].nticks; n++) tick(vecs[v].ch);
            repeat (2) clk1();
            chk($sformatf("vec%0d_val", v), val(vecs[v].ch), vecs[v].exp_val);
            chk($sformatf("vec%0d_busy", v), int'(ch_busy[vecs[v].ch]), int'(vecs[v].exp_busy));
        end

        // Write to a non-existent channel must not alias onto a real one.
        cfg_write(4, 5, 0, 0);
        repeat (2) clk1();
        chk("inv_busy", int'(ch_busy), 1);
        tick(0);
        chk("inv_ch0", val(0), 250);
        chk("inv_busy_after", int'(ch_busy), 0);

        // Arbitration: pointer parked at 2, all four pend together.
        cfg_write(0, 0, 10, 0);
        cfg_write(1, 0, 10, 0);
        cfg_write(2, 0, 10, 0);
        cfg_write(3, 100, 10, 0);
        tick(1);
        pwm_period_in = 4'hF;
        model_service(2);
        model_service(3);
        model_service(0);
        model_service(1);
        clk1();
        pwm_period_in = '0;
        clk1();
        chk("arb_ch2", val(2), 67);
        chk("arb_ch3_wait", val(3), 0);
        clk1();
        chk("arb_ch3", val(3), 10);
        chk("arb_ch0_wait", val(0), 250);
        clk1();
        chk("arb_ch0", val(0), 240);
        chk("arb_ch1_wait", val(1), 90);
        clk1();
        chk("arb_ch1", val(1), 80);

        // Overrun: channels idle at target, ch3 tick held high behind others.
        chk("ovr_clear", int'(tick_overrun), 0);
        for (int i = 0; i < NUM_CH; i++) cfg_write(i, m_cur[i], 1, 0);
        pwm_period_in = 4'hF;
        clk1();
        pwm_period_in = 4'h8;
        repeat (6) clk1();
        pwm_period_in = '0;
        repeat (8) clk1();
        chk("ovr_set", int'(tick_overrun), 1);
        repeat (20) clk1();
        chk("ovr_sticky", int'(tick_overrun), 1);

        // Collision: write lands in ch0's grant cycle; no step taken.
        cfg_write(0, 200, 10, 0);
        pwm_period_in = 4'h1;
        clk1();
        pwm_period_in    = '0;
        cfg.cfg_valid    = 1'b1;
        cfg.cfg_ch       = CH_W'(0);
        cfg.cfg_target   = 8'd50;
        cfg.cfg_step     = 8'd0;
        cfg.cfg_interval = 8'd0;
        clk1();
        cfg.cfg_valid = 1'b0;
        model_write(0, 50, 0, 0);
        chk("coll_val", val(0), 240);
        chk("coll_busy", int'(ch_busy[0]), 1);
        repeat (3) clk1();
        chk("coll_hold", val(0), 240);
        tick(0);
        chk("coll_jump", val(0), 50);

        // Reset in the middle of a free-running ramp.
        cfg_write(1, 255, 1, 0);
        tick(1);
        tick(1);
        chk("pre_rst_ramp", val(1), 82);
        mon_en        = 1'b0;
        pwm_period_in = 4'h2;
        repeat (3) clk1();
        pwm_reset = 1'b1;
        for (int r = 0; r < 2; r++) begin
            clk1();
            chk($sformatf("mid_rst%0d_ready", r), int'(cfg.cfg_ready), 0);
            chk($sformatf("mid_rst%0d_value", r), int'(pwm_value_o == '0), 1);
            chk($sformatf("mid_rst%0d_busy", r), int'(ch_busy), 0);
            chk($sformatf("mid_rst%0d_done", r), int'(ch_done), 0);
            chk($sformatf("mid_rst%0d_ovr", r), int'(tick_overrun), 0);
        end
        pwm_reset     = 1'b0;
        pwm_period_in = '0;
        model_reset();
        sb_q.delete();
        clk1();
        chk("post_rst_ready", int'(cfg.cfg_ready), 1);
        repeat (3) clk1();
        chk("post_rst_value", int'(pwm_value_o == '0), 1);
        mon_en = 1'b1;
        cfg_write(2, 9, 0, 0);
        tick(2);
        chk("post_rst_ch2", val(2), 9);

        repeat (4) clk1();
        chk("sb_empty", sb_q.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
